// File: rtl/clkdiv_pkg.sv
// Shared definitions for the programmable clock divider.
package clkdiv_pkg;

    // Smallest divisor the divider can produce; smaller requests are clamped to this.
    localparam int unsigned DIV_MIN = 2;

    typedef enum logic {
        IDLE,
        RUN
    } clkdiv_state_e;

    // Number of input cycles the posedge phase register stays high for a divisor n.
    function automatic int unsigned half_ceil(input int unsigned n);
        return (n + 1) / 2;
    endfunction

endpackage

// File: rtl/clkdiv_negedge_retime.sv
// Falling-edge retiming flop for the odd-divisor 50% duty path.
// Kept in its own module so the only negedge-clocked element is easy to find.
module clkdiv_negedge_retime (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    // Half-cycle delayed copy of d, cleared asynchronously.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/prog_clk_divider.sv
// Runtime-programmable integer clock divider, N in [2, 2^DIV_W-1].
// Divisor and enable changes are applied only at period boundaries.
// Optional macro CLKDIV_ODD50_EN: adds a negedge retime stage so odd
// divisors also produce 50% duty; without it odd N runs ceil(N/2) high.
module prog_clk_divider
    import clkdiv_pkg::*;
#(
    parameter int unsigned DIV_W       = 8,
    parameter int unsigned DEFAULT_DIV = 5
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en,
    input  logic [DIV_W-1:0] div_val,
    input  logic             div_load,
    output logic             clk_out,
    output logic [DIV_W-1:0] div_active,
    output logic             period_start,
    output logic             cfg_err
);

    localparam logic [DIV_W-1:0] DIV_RST   = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] DIV_FLOOR = DIV_W'(DIV_MIN);
    localparam logic [DIV_W-1:0] ONE       = DIV_W'(1);

    clkdiv_state_e    state;
    logic [DIV_W-1:0] count;
    logic [DIV_W-1:0] pending;
    logic [DIV_W-1:0] high_len;
    logic             wrap;
    logic             p;

    // Computed in 32 bits so N = 2^DIV_W-1 cannot overflow the +1.
    assign high_len = DIV_W'(half_ceil(32'(div_active)));
    assign wrap     = (count == div_active - ONE);

    // Pending divisor capture; out-of-range requests clamp and flag cfg_err.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            pending <= DIV_RST;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= 1'b0;
            if (div_load) begin
                if (div_val < DIV_FLOOR) begin
                    pending <= DIV_FLOOR;
                    cfg_err <= 1'b1;
                end else begin
                    pending <= div_val;
                end
            end
        end
    end

    // Period sequencer: counts through each period, swaps divisor and honours en only at the wrap.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            count        <= '0;
            div_active   <= DIV_RST;
            p            <= 1'b0;
            period_start <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    count        <= '0;
                    p            <= 1'b0;
                    period_start <= 1'b0;
                    if (en) begin
                        div_active <= pending;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    p            <= (count < high_len);
                    period_start <= (count == '0);
                    if (wrap) begin
                        count      <= '0;
                        div_active <= pending;
                        if (!en) begin
                            state <= IDLE;
                        end
                    end else begin
                        count <= count + ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef CLKDIV_ODD50_EN
    logic n;

    clkdiv_negedge_retime u_negedge_retime (
        .clk   (clk_in),
        .rst_n (rst_n),
        .d     (p),
        .q     (n)
    );

    // div_active only changes on the edge where p is driven low, so the select never cuts a high pulse.
    assign clk_out = div_active[0] ? (p & n) : p;
`else
    assign clk_out = p;
`endif

endmodule

// File: tb/tb_prog_clk_divider.sv
// Self-checking bench for prog_clk_divider (DIV_W=8, DEFAULT_DIV=5).
// Works with or without CLKDIV_ODD50_EN defined.
`timescale 1ns/100ps
module tb_prog_clk_divider;
    import clkdiv_pkg::*;

    localparam int DIV_W = 8;
    localparam int DEF   = 5;

`ifdef CLKDIV_ODD50_EN
    localparam int HI5   = 25;
    localparam int HI255 = 1275;
    localparam int LAT5  = 15;
`else
    localparam int HI5   = 30;
    localparam int HI255 = 1280;
    localparam int LAT5  = 10;
`endif

    logic             clk_in   = 1'b0;
    logic             rst_n    = 1'b1;
    logic             en       = 1'b0;
    logic [DIV_W-1:0] div_val  = '0;
    logic             div_load = 1'b0;
    logic             clk_out;
    logic [DIV_W-1:0] div_active;
    logic             period_start;
    logic             cfg_err;

    prog_clk_divider #(
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEF)
    ) dut (
        .clk_in       (clk_in),
        .rst_n        (rst_n),
        .en           (en),
        .div_val      (div_val),
        .div_load     (div_load),
        .clk_out      (clk_out),
        .div_active   (div_active),
        .period_start (period_start),
        .cfg_err      (cfg_err)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Is half-cycle slot s of a period with divisor n high? Slot 2k is the first half of cycle k.
    function automatic bit slot_high(input int k, input int n, input int half);
        int s;
        int start;
        int len;
        s     = 2 * k + half;
        start = 0;
        len   = 2 * ((n + 1) / 2);
`ifdef CLKDIV_ODD50_EN
        if (n % 2 == 1) begin
            start = 1;
            len   = n;
        end
`endif
        return (s >= start) && (s < start + len);
    endfunction

    // Period-level model state
    bit m_run     = 0;
    int m_k       = 0;
    int m_n       = DEF;
    int m_active  = DEF;
    int m_pending = DEF;
    bit e_first   = 0;
    bit e_second  = 0;
    bit e_ps      = 0;
    bit e_cfg     = 0;

    time ps_last    = 0;
    time ps_prev    = 0;
    int  cfg_pulses = 0;

    // Advance the model one input cycle, then compare all outputs just after the posedge.
    always @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            m_run = 0; m_k = 0; m_n = DEF; m_active = DEF; m_pending = DEF;
            e_first = 0; e_second = 0; e_ps = 0; e_cfg = 0;
        end else begin
            e_first = 0; e_second = 0; e_ps = 0;
            if (!m_run) begin
                if (en) begin
                    m_run    = 1;
                    m_active = m_pending;
                    m_n      = m_active;
                    m_k      = -1;
                end
            end else begin
                m_k++;
                e_ps     = (m_k == 0);
                e_first  = slot_high(m_k, m_n, 0);
                e_second = slot_high(m_k, m_n, 1);
                if (m_k == m_n - 1) begin
                    m_active = m_pending;
                    m_n      = m_active;
                    m_k      = -1;
                    if (!en) m_run = 0;
                end
            end
            e_cfg = div_load && (int'(div_val) < int'(DIV_MIN));
            if (div_load) m_pending = (int'(div_val) < int'(DIV_MIN)) ? int'(DIV_MIN) : int'(div_val);
        end
        #1;
        check("clk_out_first_half", clk_out, e_first);
        check("div_active", div_active, m_active);
        check("period_start", period_start, e_ps);
        check("cfg_err", cfg_err, e_cfg);
        if (period_start) begin
            ps_prev = ps_last;
            ps_last = $time;
        end
        if (cfg_err) cfg_pulses++;
    end

    // Second-half clk_out comparison, just after the negedge.
    always @(negedge clk_in) begin
        #1;
        check("clk_out_second_half", clk_out, e_second);
    end

    time t_rise      = 0;
    time t_rise_prev = 0;
    time t_fall      = 0;
    int  n_rise      = 0;

    // Edge timestamps of clk_out for period / high-time measurement.
    always @(posedge clk_out) begin
        t_rise_prev = t_rise;
        t_rise      = $time;
        n_rise++;
    end

    // Falling-edge timestamp of clk_out.
    always @(negedge clk_out) t_fall = $time;

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(negedge clk_in);
            #2;
        end
    endtask

    task automatic wait_rises(input int k, input int budget);
        int target;
        target = n_rise + k;
        while (n_rise < target && budget > 0) begin
            @(negedge clk_in);
            #2;
            budget--;
        end
        check("rise_within_budget", (n_rise >= target), 1);
    endtask

    task automatic measure(input string tag, input int exp_per, input int exp_hi);
        wait_rises(1, 600);
        check({tag, "_period_ns"}, t_rise - t_rise_prev, exp_per);
        check({tag, "_high_ns"}, t_fall - t_rise_prev, exp_hi);
    endtask

    time t_en;
    int  r_saved;

    initial begin
        #1 rst_n = 1'b0;
        wait_cycles(3);
        rst_n = 1'b1;
        wait_cycles(2);
        check("reset_div_active", div_active, DEF);
        check("idle_clk_out", clk_out, 0);

        // Default divisor, first-edge latency and period
        en = 1'b1;
        t_en = $time;
        wait_rises(1, 10);
        check("first_rise_latency_n5", t_rise - (t_en + 3), LAT5);
        measure("n5", 50, HI5);
        check("period_start_spacing_n5", ps_last - ps_prev, 50);

        // Mid-period load of 4: current period completes first
        div_val = 8'd4; div_load = 1'b1;
        wait_cycles(1);
        div_load = 1'b0;
        check("div_active_before_wrap", div_active, 5);
        wait_rises(1, 20);
        check("div_active_n4", div_active, 4);
        measure("n4", 40, 20);

        // Out-of-range load coincident with the wrap: clamped to 2, applied one period later
        wait_cycles(2);
        div_val = 8'd1; div_load = 1'b1;
        wait_cycles(1);
        div_load = 1'b0;
        wait_rises(1, 20);
        check("div_active_after_wrap_load", div_active, 4);
        wait_rises(1, 20);
        check("div_active_clamped", div_active, 2);
        measure("n2", 20, 10);
        check("cfg_err_pulses", cfg_pulses, 1);

        // N=6, drop en at count 1: period completes, then idle
        div_val = 8'd6; div_load = 1'b1;
        wait_cycles(1);
        div_load = 1'b0;
        wait_rises(2, 20);
        check("div_active_n6", div_active, 6);
        en = 1'b0;
        wait_cycles(8);
        check("n6_last_high_ns", t_fall - t_rise, 30);
        r_saved = n_rise;
        wait_cycles(10);
        check("idle_no_rises", n_rise, r_saved);
        check("idle_clk_low", clk_out, 0);

        // Restart latency, then en low-high glitch inside one period
        en = 1'b1;
        t_en = $time;
        wait_rises(1, 20);
        check("first_rise_latency_n6", t_rise - (t_en + 3), 10);
        en = 1'b0;
        wait_cycles(1);
        en = 1'b1;
        measure("n6_toggle", 60, 30);

        // Maximum divisor
        div_val = 8'd255; div_load = 1'b1;
        wait_cycles(1);
        div_load = 1'b0;
        wait_rises(1, 20);
        check("div_active_n255", div_active, 255);
        measure("n255", 2550, HI255);

        // Short reset pulse during the high phase
        wait_cycles(5);
        @(posedge clk_in);
        #1.5;
        check("pre_reset_clk_high", clk_out, 1);
        rst_n = 1'b0;
        #1;
        check("reset_clk_low_async", clk_out, 0);
        #2;
        rst_n = 1'b1;
        #0.2;
        check("post_reset_div_active", div_active, DEF);
        check("post_reset_period_start", period_start, 0);
        check("post_reset_cfg_err", cfg_err, 0);
        wait_rises(1, 20);
        measure("n5_after_reset", 50, HI5);

        wait_cycles(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time bound on the whole run.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/prog_clk_divider.md
Name: prog_clk_divider

Overview:
- Runtime-programmable integer clock divider: divides clk_in by any N in [2, 2^DIV_W-1].
- 50% duty for even N; 50% duty for odd N when the optional feature is compiled in.
- Divisor changes and enable/disable take effect only at output-period boundaries, so clk_out never glitches.
- Sits next to the existing fixed odd divider and generates derived clocks for peripheral and test logic.

Parameters:
- DIV_W, 8: width of divisor and counter.
- DEFAULT_DIV, 5: active divisor after reset. Must be in [2, 2^DIV_W-1].

Ports:
- clk_in  input  1  source clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  divider enable. Level-sensitive, sampled on posedge clk_in.
- div_val  input  DIV_W  requested divisor.
- div_load  input  1  one-cycle strobe. Captures div_val into the pending register.
- clk_out  output  1  divided clock.
- div_active  output  DIV_W  divisor currently in effect.
- period_start  output  1  one-clk_in-cycle pulse when count==0 of a running period.
- cfg_err  output  1  one-cycle pulse when a loaded div_val < 2.

Behaviour:
- Reset values (async assert, sync release on posedge):
  - count=0, clk_out=0, period_start=0, cfg_err=0.
  - div_active=DEFAULT_DIV, pending=DEFAULT_DIV, running=0.
- Load:
  - div_load=1 on a posedge sets pending=div_val.
  - If div_val<2: pending=2 and cfg_err=1 on the next cycle.
  - Back-to-back loads: last one wins.
- State machine (posedge clk_in):
  - IDLE: count=0, clk_out low. If en=1: div_active<=pending, go RUN, count starts at 0 next cycle.
  - RUN: count increments mod div_active.
    - At the wrap cycle (count==div_active-1): div_active<=pending and count<=0.
    - If en=0 at the wrap cycle: go IDLE. The current period always completes.
- Output phase, where N=div_active:
  - p register (posedge) = (count < ceil(N/2)) while RUN, else 0.
  - Even N: clk_out=p → high N/2 cycles, low N/2 cycles.
  - Odd N: see Optional Feature.
- period_start asserts on the posedge that registers count==0 in RUN.
- Latency:
  - First clk_out rising edge is 1 clk_in cycle after en is sampled high (IDLE→RUN edge + p register).
  - A new divisor applies from the first period after the current wrap.
- Boundary conditions:
  - div_load coincident with a wrap cycle: the new value is captured in pending and applied at the *next* wrap. Pending updates after the wrap comparison.
  - en drop mid-period: ignored until the wrap.
  - en toggling low-high within one period: no effect.
  - rst_n assert mid-period: clk_out drops low asynchronously. This is the only permitted short pulse.
  - N=2^DIV_W-1: count must not overflow. Use a DIV_W-bit compare.

Optional Feature:
- Macro: CLKDIV_ODD50_EN.
- Defined:
  - A negedge register n samples p; for odd N, clk_out = p & n.
  - Result: high N/2 input periods (e.g. 2.5 of 5), i.e. 50% duty.
  - Even N is unaffected (clk_out=p).
  - n resets to 0.
- Undefined:
  - Posedge logic only; clk_out=p for all N.
  - Odd N is high ceil(N/2) cycles and low floor(N/2) cycles (e.g. 3H/2L for N=5).

Decomposition:
- Package clkdiv_pkg holds:
  - DIV_MIN=2 constant.
  - typedef enum {IDLE, RUN} clkdiv_state_e.
  - Helper function half_ceil(N).
- Sub-module clkdiv_negedge_retime: negedge FF with async reset.
  - Instantiated only under CLKDIV_ODD50_EN.
  - Isolates the falling-edge logic for STA/DFT.

Test Plan:
- Reset with DEFAULT_DIV=5, en=1 → period_start every 5 clk_in cycles (50 ns at 10 ns clk_in).
  - With macro: clk_out high 25 ns / low 25 ns.
  - Without macro: high 30 ns / low 20 ns.
- div_load=1, div_val=4 mid-period → current 5-cycle period completes, then clk_out high 20 ns / low 20 ns. div_active reads 4 after the wrap.
- div_val=1 load → cfg_err pulses once, div_active becomes 2 at next wrap, clk_out = clk_in/2 (20 ns period).
- en=0 at count 1 of N=6 → clk_out finishes its 30 ns high / 30 ns low, then stays 0, state IDLE. en=1 → first rising edge 1 clk_in cycle later.
- div_val=255 (DIV_W=8) → period 2550 ns, count wraps at 254, no overflow.
  - With macro: high exactly 1275 ns.
  - Without macro: high 1280 ns.
- rst_n low for 3 ns mid-high phase → clk_out low immediately. After release, outputs match reset values and div_active=DEFAULT_DIV.
